// File: rtl/sigmoid_lut_arbiter.sv
// rtl/sigmoid_lut_arbiter.sv - round-robin arbiter sharing one sigmoid lookup ROM between requesters
module sigmoid_lut_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 14,
   parameter int DATA_WIDTH = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   output logic [NUM_REQ-1:0]            gnt,
   output logic [ADDR_WIDTH-1:0]         rom_addr,
   input  logic [DATA_WIDTH-1:0]         rom_q,
   output logic [NUM_REQ-1:0]            rsp_valid,
   output logic [DATA_WIDTH-1:0]         rsp_data
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [PTR_W-1:0] ptr;
   logic [PTR_W-1:0] win;
   logic [PTR_W-1:0] cand;
   logic             found;
   logic             s1_valid;
   logic [PTR_W-1:0] s1_id;

   // Pick the first requester at or after ptr, wrapping modulo NUM_REQ
   always_comb begin
      gnt      = '0;
      rom_addr = '0;
      found    = 1'b0;
      win      = '0;
      cand     = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = PTR_W'((32'(ptr) + 32'(k)) % 32'(NUM_REQ));
         if (!found && req[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
      if (found) begin
         gnt[win] = 1'b1;
         rom_addr = req_addr[32'(win)*ADDR_WIDTH +: ADDR_WIDTH];
      end
   end

   // Advance the pointer past the winner and tag the lookup while the ROM reads
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr      <= '0;
         s1_valid <= 1'b0;
         s1_id    <= '0;
      end else begin
         s1_valid <= found;
         if (found) begin
            s1_id <= win;
            ptr   <= (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
         end
      end
   end

   // Register the ROM word and route it to the requester that issued the lookup
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid <= '0;
         rsp_data  <= '0;
      end else if (s1_valid) begin
         rsp_valid <= NUM_REQ'(1) << s1_id;
         rsp_data  <= rom_q;
      end else begin
         rsp_valid <= '0;
      end
   end

endmodule

// File: tb/tb_sigmoid_lut_arbiter.sv
// tb/tb_sigmoid_lut_arbiter.sv - self-checking bench for sigmoid_lut_arbiter
module tb_sigmoid_lut_arbiter;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req;
   logic [55:0] req_addr;
   logic [3:0]  gnt;
   logic [13:0] rom_addr;
   logic [7:0]  rom_q;
   logic [3:0]  rsp_valid;
   logic [7:0]  rsp_data;

   sigmoid_lut_arbiter #(
      .NUM_REQ   (4),
      .ADDR_WIDTH(14),
      .DATA_WIDTH(8)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .req_addr (req_addr),
      .gnt      (gnt),
      .rom_addr (rom_addr),
      .rom_q    (rom_q),
      .rsp_valid(rsp_valid),
      .rsp_data (rsp_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bench ROM: data[a] = a[7:0] ^ 8'hA5, one-cycle registered read
   always @(posedge clk) rom_q <= rom_addr[7:0] ^ 8'hA5;

   typedef struct packed {
      logic [3:0]  r;
      logic [55:0] a;
      logic [3:0]  eg;
   } vec_t;

   typedef struct {
      int         due;
      logic [3:0] id;
      logic [7:0] data;
   } sb_t;

   vec_t vecs[$];
   sb_t  sb[$];
   int   cyc;
   int   checks;
   int   errors;

   function automatic logic [55:0] pk(input int a0, input int a1, input int a2, input int a3);
      return {14'(a3), 14'(a2), 14'(a1), 14'(a0)};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [13:0] slice_of(input logic [55:0] a, input logic [3:0] oh);
      logic [13:0] s;
      s = '0;
      for (int i = 0; i < 4; i++)
         if (oh[i]) s = a[i*14 +: 14];
      return s;
   endfunction

   // One clock cycle: drive, check grant, queue expected response, check delivered response
   task automatic cycle(input logic [3:0] r, input logic [55:0] a, input logic [3:0] eg);
      sb_t e;
      logic [13:0] ea;
      @(posedge clk);
      #1;
      req      = r;
      req_addr = a;
      @(negedge clk);
      chk("gnt", 32'(gnt), 32'(eg));
      ea = slice_of(a, eg);
      chk("rom_addr", 32'(rom_addr), 32'(ea));
      if (eg != 4'b0) begin
         e.due  = cyc + 2;
         e.id   = eg;
         e.data = ea[7:0] ^ 8'hA5;
         sb.push_back(e);
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
         e = sb.pop_front();
         chk("rsp_valid", 32'(rsp_valid), 32'(e.id));
         chk("rsp_data", 32'(rsp_data), 32'(e.data));
      end else begin
         chk("rsp_idle", 32'(rsp_valid), 32'h0);
      end
      cyc++;
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      cyc      = 0;
      rst_n    = 1'b0;
      req      = 4'b0;
      req_addr = '0;

      // Reset state, and grant follows req combinationally with ptr=0
      @(negedge clk);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_rsp_data", 32'(rsp_data), 32'h0);
      chk("rst_gnt_idle", 32'(gnt), 32'h0);
      req      = 4'b1010;
      req_addr = pk(0, 14'h0123, 0, 14'h0456);
      #1;
      chk("rst_gnt_comb", 32'(gnt), 32'h2);
      chk("rst_rom_addr", 32'(rom_addr), 32'h0123);
      req   = 4'b0;
      rst_n = 1'b1;

      // Full contention from reset: rotate 0,1,2,3 twice
      for (int i = 0; i < 8; i++)
         vecs.push_back('{r: 4'b1111, a: pk(0, 1, 2, 3), eg: 4'(1 << (i % 4))});
      for (int i = 0; i < 3; i++) vecs.push_back('{r: 4'b0, a: '0, eg: 4'b0});
      // Single requester 2 at 0x0013 -> 0xB6
      vecs.push_back('{r: 4'b0100, a: pk(0, 0, 14'h0013, 0), eg: 4'b0100});
      for (int i = 0; i < 3; i++) vecs.push_back('{r: 4'b0, a: '0, eg: 4'b0});
      // Round-robin skip: grant 1, then 3 ahead of 0, then ptr wrapped to 0
      vecs.push_back('{r: 4'b0010, a: pk(0, 14'h0011, 0, 0), eg: 4'b0010});
      vecs.push_back('{r: 4'b1001, a: pk(14'h0020, 0, 0, 14'h0033), eg: 4'b1000});
      vecs.push_back('{r: 4'b1001, a: pk(14'h0020, 0, 0, 14'h0034), eg: 4'b0001});
      vecs.push_back('{r: 4'b1000, a: pk(0, 0, 0, 14'h0034), eg: 4'b1000});
      for (int i = 0; i < 3; i++) vecs.push_back('{r: 4'b0, a: '0, eg: 4'b0});
      // Streaming on requester 1, addresses 0..7
      for (int i = 0; i < 8; i++)
         vecs.push_back('{r: 4'b0010, a: pk(0, i, 0, 0), eg: 4'b0010});
      for (int i = 0; i < 3; i++) vecs.push_back('{r: 4'b0, a: '0, eg: 4'b0});

      for (int i = 0; i < vecs.size(); i++)
         cycle(vecs[i].r, vecs[i].a, vecs[i].eg);

      // Explicit check of the documented single-lookup data word
      cycle(4'b0100, pk(0, 0, 14'h0013, 0), 4'b0100);
      cycle(4'b0, '0, 4'b0);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("single_b6_valid", 32'(rsp_valid), 32'h4);
      chk("single_b6_data", 32'(rsp_data), 32'hB6);
      void'(sb.pop_front());
      cyc++;

      // Reset mid-flight: grant to 2 (ptr -> 3), reset during the ROM read
      cycle(4'b0100, pk(0, 0, 14'h0055, 0), 4'b0100);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      req   = 4'b0;
      @(negedge clk);
      chk("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("midrst_rsp_data", 32'(rsp_data), 32'h0);
      sb.delete();
      cyc++;
      rst_n = 1'b1;
      cycle(4'b1111, pk(14'h0007, 1, 2, 3), 4'b0001);
      for (int i = 0; i < 4; i++) cycle(4'b0, '0, 4'b0);

      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sigmoid_lut_arbiter.md
# sigmoid_lut_arbiter

Round-robin arbiter that shares one synchronous-read sigmoid lookup ROM (1-cycle registered read, 2^ADDR_WIDTH x DATA_WIDTH) between NUM_REQ neuron activation units. It sits between the neuron datapaths and the ROM instance. It issues at most one lookup per clock and tags each lookup with its requester index. It returns the ROM word to the requester that issued it, in a fixed-latency pipeline.

## Interface
- NUM_REQ, 4: number of requesters; legal range 2..16.
- ADDR_WIDTH, 14: ROM address width (width of one requester address).
- DATA_WIDTH, 8: ROM data width.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  NUM_REQ  per-requester lookup request; held high with a stable address until granted.
- req_addr  input  NUM_REQ*ADDR_WIDTH  packed addresses; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- gnt  output  NUM_REQ  one-hot or zero, combinational; gnt[i] high means the request is accepted this cycle.
- rom_addr  output  ADDR_WIDTH  address to the ROM, combinational from the winner.
- rom_q  input  DATA_WIDTH  ROM read data; valid one cycle after the ROM samples rom_addr.
- rsp_valid  output  NUM_REQ  one-hot or zero, registered; rsp_valid[i] marks the response for requester i.
- rsp_data  output  DATA_WIDTH  registered response word, shared by all requesters; qualified by rsp_valid.

## Operation
- Arbitration:
  - Round-robin pointer ptr, width clog2(NUM_REQ).
  - Each cycle the winner is the first i with req[i]=1, searching ptr, ptr+1, ..., wrapping modulo NUM_REQ.
  - If req is all zero: gnt=0, no lookup issued, ptr unchanged.
  - On a grant to index w, ptr <= (w+1) mod NUM_REQ at the clock edge. Wrap from NUM_REQ-1 goes to 0.
- Handshake: a request is accepted in the cycle gnt[i]=1.
  - The requester drops req or presents its next address in the following cycle.
  - Back-to-back requests from a single requester are accepted every cycle when no other requester is active.
- rom_addr: equals req_addr slice of the winner; 0 when there is no grant.
- Pipeline stages, all flops cleared by reset:
  - s1_valid, s1_id: loaded at the grant edge with (1, w), or (0, s1_id unchanged) when there is no grant.
  - Response stage: when s1_valid=1, rsp_data <= rom_q and rsp_valid <= one-hot(s1_id). Otherwise rsp_valid <= 0 and rsp_data holds its previous value.
- Throughput: one lookup per cycle sustained. No backpressure on responses; requesters must accept rsp_valid whenever it is asserted.
- Fairness: with all NUM_REQ requesting continuously, grants rotate 0,1,...,NUM_REQ-1,0,... Each requester is granted exactly once per NUM_REQ cycles.
- Reset:
  - Asynchronous assert clears ptr=0, s1_valid=0, s1_id=0, rsp_valid=0, rsp_data=0.
  - In-flight lookups are discarded and produce no response.
  - gnt and rom_addr are combinational and follow req immediately, with ptr=0.
  - Deassertion is synchronized externally. The first grant occurs at the first rising edge after rst_n goes high.

## Timing
- Grant in cycle T (combinational on req and ptr).
- The ROM samples rom_addr at the end of T, and rom_q is valid during T+1.
- rsp_valid and rsp_data are asserted during cycle T+2. Latency is 2 clocks from grant to response, fixed and independent of contention.
- Worst-case wait from req assertion to gnt is NUM_REQ-1 cycles.
- Simultaneous events:
  - A new grant in T+1 and a response for the T grant in T+2 coexist without interaction.
  - A requester may be granted again in the same cycle its earlier response is delivered.
- Reset asserted during cycle T+1 of a lookup: no rsp_valid for that lookup, ever.

## Test plan
- The bench ROM is loaded so that data[a] = a[7:0] XOR 8'hA5, with NUM_REQ=4.
- Single requester: req[2]=1, addr=14'h0013, for one cycle. Expect gnt=4'b0100 the same cycle, rom_addr=14'h0013, then rsp_valid=4'b0100 and rsp_data=8'hB6 exactly 2 cycles later. No other rsp_valid pulses.
- Full contention: all four hold req with addr=i. Expect the gnt sequence 0001,0010,0100,1000 repeating from reset. Expect rsp_valid to follow the same sequence delayed by 2 cycles, with rsp_data = i XOR A5.
- Round-robin skip: after a grant to 1, only req[0] and req[3] are high. Expect 3 to be granted before 0, and ptr to wrap to 0.
- Streaming: req[1] held high for 8 cycles with addresses 0..7. Expect 8 consecutive gnt, then 8 consecutive rsp_valid=4'b0010 with data 8'hA5..8'hA2.
- Reset mid-flight: grant a lookup, then assert rst_n=0 in the next cycle. Expect rsp_valid=0 and rsp_data=0 immediately, no response after release, and the first post-reset grant to go to the lowest-index requester.
